// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : result_drain
//  Description : Captures complete N x N result matrices from a systolic array
//                into a two-entry ping-pong buffer and streams them out one
//                element per handshake, in row-major order.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_drain #(
  parameter int N  = 3,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*N*DW-1:0] c_in,
  input  logic              c_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam int          c_NELEM    = N * N;
  localparam logic [3:0]  c_LAST_IDX = 4'(c_NELEM - 1);
  localparam logic [1:0]  c_FULL     = 2'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_c_valid_q;
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;
  logic [3:0]          r_idx;
  logic                r_overflow;
  logic [N*N*DW-1:0]   r_buf [0:1];

  logic                w_capture;
  logic                w_accept;
  logic                w_hs;
  logic                w_final_hs;
  logic [N*N*DW-1:0]   w_rd_mat;
  logic [DW-1:0]       w_elems [0:c_NELEM-1];
  logic [DW-1:0]       w_elem;

  // A capture is the rising edge of c_valid; only accepted while a slot is free.
  assign w_capture  = c_valid & ~r_c_valid_q;
  assign w_accept   = w_capture & (r_count != c_FULL);
  assign w_hs       = out_valid & out_ready;
  assign w_final_hs = w_hs & (r_idx == c_LAST_IDX);

  // Delayed copy of c_valid for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_c_valid_q <= 1'b0;
    else     r_c_valid_q <= c_valid;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave DRAIN only when the last buffered matrix finishes and
  // nothing new arrives in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_capture) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_final_hs && !w_capture && (r_count == 2'd1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Occupancy counter, ping-pong pointers, element index and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_idx      <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_accept, w_final_hs})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_accept)   r_wptr <= ~r_wptr;
      if (w_final_hs) r_rptr <= ~r_rptr;
      if (w_hs) begin
        if (w_final_hs) r_idx <= 4'd0;
        else            r_idx <= r_idx + 4'd1;
      end
      if (w_capture && (r_count == c_FULL)) r_overflow <= 1'b1;
    end
  end

  // Matrix storage; contents are only observable through the gated output mux,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wptr] <= c_in;
  end

  assign w_rd_mat = r_buf[r_rptr];

  generate
    for (genvar g = 0; g < c_NELEM; g++) begin : g_unpack
      assign w_elems[g] = w_rd_mat[g*DW +: DW];
    end
  endgenerate

  // Select the element currently addressed by the drain index.
  always_comb begin
    w_elem = '0;
    for (int i = 0; i < c_NELEM; i++) begin
      if (r_idx == 4'(i)) w_elem = w_elems[i];
    end
  end

  assign out_valid = (r_state == DRAIN);
  assign out_data  = out_valid ? w_elem : '0;
  assign out_idx   = r_idx;
  assign out_last  = out_valid & (r_idx == c_LAST_IDX);
  assign busy      = (r_count != 2'd0);
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_drain
//  Description : Self-checking bench for result_drain: queue-based reference
//                model compared every cycle, plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int NE = N * N;

  logic              clk;
  logic              rst;
  logic [NE*DW-1:0]  c_in;
  logic              c_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              busy;
  logic              overflow;

  result_drain #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .c_in(c_in), .c_valid(c_valid), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;

  int MA [NE] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
  int MB [NE] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  // Reference model: list of buffered matrices and position in the head one.
  logic [NE*DW-1:0] mq [$];
  int               m_pos   = 0;
  logic             m_prev  = 1'b0;
  logic             m_ovf   = 1'b0;

  // Observation records.
  int got [$];
  int vcnt    = 0;
  int bubbles = 0;
  bit seen_v  = 0;
  bit gap     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NE*DW-1:0] pack(input int v [NE]);
    logic [NE*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NE; i++) r[i*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  // Model update on each clock edge; reset clears everything immediately.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pos  = 0;
      m_prev = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      int  sz;
      bit  hs;
      sz = mq.size();
      hs = (sz > 0) && out_ready;
      if (c_valid && !m_prev) begin
        if (sz < 2) mq.push_back(c_in);
        else        m_ovf = 1'b1;
      end
      if (hs) begin
        m_pos++;
        if (m_pos == NE) begin
          m_pos = 0;
          void'(mq.pop_front());
        end
      end
      m_prev = c_valid;
    end
  end

  // Compare DUT against the model mid-cycle and record delivered elements.
  always @(negedge clk) begin
    if (!rst) begin
      logic [NE*DW-1:0] hm;
      bit ev;
      ev = (mq.size() > 0);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(ev));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (ev) begin
        hm = mq[0];
        chk("out_data", 32'(out_data), 32'(hm[m_pos*DW +: DW]));
        chk("out_idx", 32'(out_idx), 32'(m_pos));
        chk("out_last", 32'(out_last), 32'(m_pos == NE - 1));
      end
      if (out_valid) begin
        vcnt++;
        if (gap) bubbles++;
        seen_v = 1;
        gap    = 0;
        if (out_ready) got.push_back(int'(out_data));
      end else if (seen_v) begin
        gap = 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got.delete();
    vcnt    = 0;
    bubbles = 0;
    seen_v  = 0;
    gap     = 0;
  endtask

  task automatic capture_pulse(input int v [NE]);
    @(posedge clk); #1;
    c_in    = pack(v);
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_got(input string nm, input int exp [$]);
    chk({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(nm, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    int expq [$];
    int k;
    rst = 1'b1; c_in = '0; c_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_out_data", 32'(out_data), 0);
    step(2);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // Single drain with latency check.
    clear_obs();
    out_ready = 1'b1;
    capture_pulse(MA);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 1);
    chk("first_data", 32'(out_data), 30);
    step(12);
    expq = {30, 36, 42, 66, 81, 96, 102, 126, 150};
    chk_got("single", expq);
    chk("single_vcnt", 32'(vcnt), 9);
    chk("single_busy_end", 32'(busy), 0);

    // Backpressure with ready pattern 1,0,0,...
    clear_obs();
    capture_pulse(MA);
    for (int i = 0; i < 40; i++) begin
      out_ready = ((i % 3) == 0);
      step(1);
    end
    out_ready = 1'b1;
    step(2);
    chk_got("backpressure", expq);

    // Back-to-back capture during a drain: no bubble between matrices.
    clear_obs();
    capture_pulse(MA);
    capture_pulse(MB);
    step(25);
    expq = {30, 36, 42, 66, 81, 96, 102, 126, 150, 30, 24, 18, 84, 69, 54, 138, 114, 90};
    chk_got("b2b", expq);
    chk("b2b_vcnt", 32'(vcnt), 18);
    chk("b2b_bubbles", 32'(bubbles), 0);

    // Overflow: third capture while both slots are full is dropped.
    clear_obs();
    out_ready = 1'b0;
    capture_pulse(MA);
    capture_pulse(MB);
    capture_pulse(MA);
    step(2);
    chk("ovf_set", 32'(overflow), 1);
    out_ready = 1'b1;
    step(25);
    chk_got("ovf_drain", expq);
    chk("ovf_sticky", 32'(overflow), 1);

    // Held-high c_valid yields one matrix.
    do_reset();
    chk("ovf_cleared", 32'(overflow), 0);
    clear_obs();
    c_in = pack(MA);
    c_valid = 1'b1;
    step(20);
    c_valid = 1'b0;
    step(5);
    expq = {30, 36, 42, 66, 81, 96, 102, 126, 150};
    chk_got("held", expq);
    chk("held_vcnt", 32'(vcnt), 9);

    // c_valid already high when reset releases counts as a capture.
    rst = 1'b1;
    c_in = pack(MB);
    c_valid = 1'b1;
    step(2);
    @(posedge clk); #1;
    clear_obs();
    rst = 1'b0;
    step(12);
    c_valid = 1'b0;
    step(2);
    expq = {30, 24, 18, 84, 69, 54, 138, 114, 90};
    chk_got("rst_release_cap", expq);

    // Reset in the middle of a drain.
    clear_obs();
    capture_pulse(MA);
    k = 0;
    while (got.size() < 5 && k < 40) begin
      step(1);
      k++;
    end
    chk("mid_wait_done", 32'(got.size() >= 5), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_idx", 32'(out_idx), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    step(2);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    step(15);
    chk("post_rst_vcnt", 32'(vcnt), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the systolic array dimension (N x N result elements).
REQ-002 The block SHALL have parameter DW, default 16, meaning the width of one result element in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 The block SHALL have port c_in, input, N*N*DW (144), the array result bus; element i = c_in[i*DW +: DW], i = 0..N*N-1, in row-major order C11, C12, ..., CNN.
REQ-006 The block SHALL have port c_valid, input, 1, the array result-valid level, held high while c_in is valid.
REQ-007 The block SHALL have port out_ready, input, 1, the downstream consumer ready.
REQ-008 The block SHALL have port out_data, output, DW, the current result element.
REQ-009 The block SHALL have port out_valid, output, 1, high when out_data is valid.
REQ-010 The block SHALL have port out_idx, output, 4, the index i of the element on out_data.
REQ-011 The block SHALL have port out_last, output, 1, high with element N*N-1 of each matrix.
REQ-012 The block SHALL have port busy, output, 1, high when at least one matrix is buffered.
REQ-013 The block SHALL have port overflow, output, 1, a sticky flag for a dropped result.

Function
REQ-014 The block SHALL register c_valid into c_valid_q and define a capture event as c_valid=1 and c_valid_q=0 at a clk edge; a held-high c_valid SHALL produce exactly one capture.
REQ-015 The block SHALL hold a 2-entry matrix buffer (ping-pong) with write pointer, read pointer and count 0..2.
REQ-016 On a capture event with count<2, the block SHALL store c_in into the write-pointer entry at that edge, toggle the write pointer and increment count.
REQ-017 On a capture event with count=2, the block SHALL discard c_in, leave the buffer unchanged and set overflow=1 until reset.
REQ-018 The FSM SHALL have exactly two states: IDLE (count=0) and DRAIN (count>0). IDLE->DRAIN on capture; DRAIN->IDLE on the final handshake when no capture occurs in the same cycle.
REQ-019 In DRAIN, out_valid SHALL be 1, and out_data SHALL equal element idx of the read-pointer entry, with out_idx=idx.
REQ-020 A handshake SHALL occur when out_valid=1 and out_ready=1 at an edge; idx SHALL advance 0..N*N-1 only on a handshake.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-022 On the handshake at idx=N*N-1, the block SHALL wrap idx to 0, toggle the read pointer and decrement count.
REQ-023 A capture event and a final handshake in the same cycle SHALL leave count unchanged and keep the FSM in DRAIN; the next matrix SHALL present element 0 in the following cycle with no bubble.
REQ-024 First-element latency SHALL be one cycle: out_valid rises in the cycle after the capture edge when starting from IDLE.
REQ-025 With out_ready held 1, one matrix SHALL drain in exactly N*N consecutive cycles.
REQ-026 busy SHALL equal (count != 0).

Reset
REQ-027 While rst=1, regardless of the clock, the block SHALL set out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0, overflow=0, count=0, both pointers=0, idx=0, c_valid_q=0 and state=IDLE.
REQ-028 Assertion of rst mid-drain SHALL discard all buffered data; after rst deasserts, the block SHALL capture no data until a new capture event.
REQ-029 If c_valid is already high when rst deasserts, the block SHALL treat it as a capture event at the first clock edge.

Verification
REQ-030 Single drain: capture C=[30,36,42,66,81,96,102,126,150] with out_ready=1 -> out_valid rises 1 cycle later; elements 30..150 appear on 9 consecutive cycles with out_idx 0..8; out_last=1 only with 150; busy then drops.
REQ-031 Backpressure: drive out_ready as 1,0,0,1,... -> each element is held while out_ready=0; the sequence is the same 9 values with no loss or duplication.
REQ-032 Back-to-back: capture the above matrix, then capture [30,24,18,84,69,54,138,114,90] during the drain -> 18 elements are delivered in order, with no bubble between 150 and 30.
REQ-033 Overflow: with out_ready=0, issue 3 capture events -> overflow=1 and stays 1; after out_ready=1, only the first two matrices are drained.
REQ-034 Held valid: hold c_valid=1 for 20 cycles -> exactly one matrix (9 elements) is delivered.
REQ-035 Reset mid-drain: assert rst after element 4 -> all outputs are 0 immediately (asynchronously); after rst deasserts with c_valid=0, no output appears.
